decode_stage: RTL

//  Producer side of the ALU opcode interface. Decodes one RV32I instruction per beat into an
//  ALU_* opcode, operand selects, a sign-extended immediate and register addresses, then

---
 rtl/decode_stage_pkg.sv | 75 +++++++
 rtl/decode_stage_imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared codes for the RV32I decode stage: ALU ops, operand selects, major opcodes,
// immediate formats and the registered control bundle.
package decode_stage_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_CMP  = 5'd3;
    localparam logic [4:0] ALU_UCMP = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic       SRC2_RS2  = 1'b0;
    localparam logic       SRC2_IMM  = 1'b1;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] src1_sel;
        logic       src2_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rd_we;
        logic       is_branch;
        logic [2:0] br_cond;
        logic       is_jump;
        logic [1:0] is_mem;
        logic       illegal;
    } ctrl_t;

    // alt selects SUB over ADD and SRA over SRL (instr[30] where the encoding allows it)
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_CMP;
            3'b011:  return ALU_UCMP;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extractor: instruction word plus format code in,
// sign-extended immediate out.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic        s;
    logic [31:0] imm32;

    assign s = instr_i[31];

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I:     imm32 = {{20{s}}, instr_i[31:20]};
            IMM_S:     imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     imm32 = {{20{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm32 = {instr_i[31:12], 12'd0};
            IMM_J:     imm32 = {{12{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'd0, instr_i[24:20]};
            default:   imm32 = '0;
        endcase
    end

    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage between fetch and execute, registered output with valid/ready.
// Define DECODE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_op,
    output logic [1:0]      src1_sel,
    output logic            src2_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            is_branch,
    output logic [2:0]      br_cond,
    output logic            is_jump,
    output logic [1:0]      is_mem,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam int BW = $bits(ctrl_t) + 2 * XLEN;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal;
    ctrl_t           dec_ctrl;
    imm_fmt_e        dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic [BW-1:0]   in_beat;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_ctrl     = '0;
        dec_fmt      = IMM_NONE;
        legal        = 1'b1;
        dec_ctrl.rs1 = in_instr[19:15];
        dec_ctrl.rs2 = in_instr[24:20];
        dec_ctrl.rd  = in_instr[11:7];
        case (opcode)
            OPC_LUI: begin
                dec_ctrl.src1_sel = SRC1_ZERO;
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.rd_we    = 1'b1;
                dec_fmt           = IMM_U;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec_ctrl.src1_sel = SRC1_PC;
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.rd_we    = 1'b1;
                dec_ctrl.is_jump  = (opcode == OPC_JAL);
                dec_fmt           = (opcode == OPC_JAL) ? IMM_J : IMM_U;
            end
            OPC_JALR: begin
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.rd_we    = 1'b1;
                dec_ctrl.is_jump  = 1'b1;
                dec_fmt           = IMM_I;
                legal             = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec_ctrl.is_branch = 1'b1;
                dec_ctrl.br_cond   = funct3;
                dec_fmt            = IMM_B;
                case (funct3[2:1])
                    2'b00:   dec_ctrl.alu_op = ALU_SUB;
                    2'b10:   dec_ctrl.alu_op = ALU_CMP;
                    2'b11:   dec_ctrl.alu_op = ALU_UCMP;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.rd_we    = 1'b1;
                dec_ctrl.is_mem   = MEM_LOAD;
                dec_fmt           = IMM_I;
                legal             = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.is_mem   = MEM_STORE;
                dec_fmt           = IMM_S;
                legal             = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            end
            OPC_OPIMM: begin
                dec_ctrl.src2_sel = SRC2_IMM;
                dec_ctrl.rd_we    = 1'b1;
                dec_ctrl.alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && in_instr[30]);
                dec_fmt           = IMM_I;
                // shift-immediates carry a shamt; their funct7 must be a known shift flavour
                if (funct3 == 3'b001) begin
                    dec_fmt = IMM_SHAMT;
                    legal   = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    dec_fmt = IMM_SHAMT;
                    legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
                end
            end
            OPC_OP: begin
                dec_ctrl.rd_we  = 1'b1;
                dec_ctrl.alu_op = alu_from_funct3(funct3, in_instr[30]);
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: legal = 1'b0;
        endcase

        // illegal beats keep only the raw register fields and the illegal flag
        if (!legal) begin
            dec_ctrl         = '0;
            dec_ctrl.rs1     = in_instr[19:15];
            dec_ctrl.rs2     = in_instr[24:20];
            dec_ctrl.rd      = in_instr[11:7];
            dec_ctrl.illegal = 1'b1;
            dec_fmt          = IMM_NONE;
        end
        if (dec_ctrl.rd == 5'd0) begin
            dec_ctrl.rd_we = 1'b0;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .fmt_i   (dec_fmt),
        .imm_o   (dec_imm)
    );

    assign in_beat = {dec_ctrl, dec_imm, in_pc};

    // Handshake: a beat moves on a side when valid && ready at the rising edge; a held
    // output beat keeps valid high and payload stable until accepted or flushed.
    logic          main_valid_q, main_valid_d;
    logic [BW-1:0] main_q, main_d;

`ifdef DECODE_STAGE_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [BW-1:0] skid_q, skid_d;
    logic          in_ready_q;
    logic          accept;
    logic          pop;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;
    assign pop      = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            // in_ready is low whenever skid is full, so skid and accept never collide
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = in_beat;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_ready) begin
            main_valid_d = in_valid;
            if (in_valid) main_d = in_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
        end
    end
`endif

    ctrl_t out_ctrl;

    assign {out_ctrl, imm, out_pc} = main_q;
    assign out_valid = main_valid_q;
    assign alu_op    = out_ctrl.alu_op;
    assign src1_sel  = out_ctrl.src1_sel;
    assign src2_sel  = out_ctrl.src2_sel;
    assign rs1       = out_ctrl.rs1;
    assign rs2       = out_ctrl.rs2;
    assign rd        = out_ctrl.rd;
    assign rd_we     = out_ctrl.rd_we;
    assign is_branch = out_ctrl.is_branch;
    assign br_cond   = out_ctrl.br_cond;
    assign is_jump   = out_ctrl.is_jump;
    assign is_mem    = out_ctrl.is_mem;
    assign illegal   = out_ctrl.illegal;

endmodule
